// File: rtl/circular_buffer_scheduler.sv
// Write-port arbiter and pointer/occupancy controller for an external circular buffer.
// Optional `DROP_COUNT_EN adds an 8-bit saturating count of requests refused because the buffer was full.
module circular_buffer_scheduler #(
   parameter int buff_size = 4,
   parameter int word_size = 8,
   parameter int addr_size = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_a,
   input  logic [word_size-1:0] data_a,
   output logic                 grant_a,
   input  logic                 req_b,
   input  logic [word_size-1:0] data_b,
   output logic                 grant_b,
   output logic                 wr_en,
   output logic [addr_size-1:0] wr_addr,
   output logic [word_size-1:0] wr_data,
   output logic [addr_size-1:0] rd_addr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [addr_size:0]   count,
   output logic                 full,
   output logic                 empty
`ifdef DROP_COUNT_EN
   ,
   output logic [7:0]           drop_count
`endif
);

   localparam logic [addr_size:0]   FULL_CNT = (addr_size + 1)'(buff_size);
   localparam logic [addr_size:0]   CNT_ONE  = {{addr_size{1'b0}}, 1'b1};
   localparam logic [addr_size-1:0] PTR_ONE  = {{(addr_size - 1){1'b0}}, 1'b1};

   logic [addr_size-1:0] wr_ptr_q, wr_ptr_d;
   logic [addr_size-1:0] rd_ptr_q, rd_ptr_d;
   logic [addr_size:0]   count_q, count_d;
   logic                 last_grant_q, last_grant_d;
   logic                 push, pop;

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign out_valid = !empty;
   assign rd_addr   = rd_ptr_q;
   assign wr_addr   = wr_ptr_q;
   assign count     = count_q;

   // last_grant_q = 1 means B was served last, so A wins the next tie.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!reset && !full) begin
         if (req_a && req_b) begin
            grant_a = last_grant_q;
            grant_b = !last_grant_q;
         end else begin
            grant_a = req_a;
            grant_b = req_b;
         end
      end
   end

   assign wr_en   = grant_a | grant_b;
   assign wr_data = grant_a ? data_a : data_b;
   assign push    = wr_en;
   assign pop     = out_valid & out_ready;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      last_grant_d = last_grant_q;
      if (push) begin
         wr_ptr_d     = wr_ptr_q + PTR_ONE;
         last_grant_d = grant_b;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         last_grant_q <= 1'b1;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         last_grant_q <= last_grant_d;
      end
   end

`ifdef DROP_COUNT_EN
   logic [7:0] drop_q, drop_d;
   logic [1:0] drop_inc;
   logic [8:0] drop_sum;

   // Only refusals caused by a full buffer count; losing arbitration does not.
   assign drop_inc = {1'b0, req_a & full} + {1'b0, req_b & full};
   assign drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};

   always_comb begin
      drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_circular_buffer_scheduler.sv
// Directed bench for circular_buffer_scheduler with a behavioural model of the external array.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_circular_buffer_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_a = 1'b0;
   logic [7:0] data_a = '0;
   logic       grant_a;
   logic       req_b = 1'b0;
   logic [7:0] data_b = '0;
   logic       grant_b;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [1:0] rd_addr;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] count;
   logic       full;
   logic       empty;
`ifdef DROP_COUNT_EN
   logic [7:0] drop_count;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mem[4];

   always #5 clock = ~clock;

   circular_buffer_scheduler #(.buff_size(4), .word_size(8), .addr_size(2)) dut (
      .clock(clock), .reset(reset),
      .req_a(req_a), .data_a(data_a), .grant_a(grant_a),
      .req_b(req_b), .data_b(data_b), .grant_b(grant_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .full(full), .empty(empty)
`ifdef DROP_COUNT_EN
      , .drop_count(drop_count)
`endif
   );

   // External storage: written on the rising edge, read combinationally.
   always @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
      data_a = '0; data_b = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b1; req_a = 1'b1; req_b = 1'b1;
      tick();
      #1;
      n_checks++;
      if (grant_a !== 1'b0 || grant_b !== 1'b0 || wr_en !== 1'b0)
         $display("FAIL reset_grants: got a=%b b=%b wr_en=%b, want 0 0 0", grant_a, grant_b, wr_en);
      else n_pass++;
      @(negedge clock);
      reset = 1'b0; idle_inputs();
      #1;
      n_checks++;
      if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL reset_flags: got count=%0d empty=%b full=%b valid=%b, want 0 1 0 0", count, empty, full, out_valid);
      else n_pass++;
      n_checks++;
      if (rd_addr !== 2'd0 || wr_addr !== 2'd0 || grant_a !== 1'b0 || grant_b !== 1'b0)
         $display("FAIL reset_addr: got rd=%0d wr=%0d ga=%b gb=%b, want 0 0 0 0", rd_addr, wr_addr, grant_a, grant_b);
      else n_pass++;
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_a = 1'b1; data_a = 8'(i + 1);
         #1;
         n_checks++;
         if (grant_a !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 2'(i) || wr_data !== 8'(i + 1))
            $display("FAIL fill_write%0d: got g=%b en=%b addr=%0d data=%0d, want 1 1 %0d %0d",
                     i, grant_a, wr_en, wr_addr, wr_data, i, i + 1);
         else n_pass++;
         tick();
      end
      req_a = 1'b0;
      #1;
      n_checks++;
      if (count !== 3'd4 || full !== 1'b1 || empty !== 1'b0)
         $display("FAIL fill_full: got count=%0d full=%b empty=%b, want 4 1 0", count, full, empty);
      else n_pass++;
      req_a = 1'b1; data_a = 8'd5;
      #1;
      n_checks++;
      if (grant_a !== 1'b0 || wr_en !== 1'b0)
         $display("FAIL fill_fifth_blocked: got g=%b en=%b, want 0 0", grant_a, wr_en);
      else n_pass++;
      tick();
      req_a = 1'b0;
      #1;
      n_checks++;
      if (count !== 3'd4)
         $display("FAIL fill_count_hold: got %0d, want 4", count);
      else n_pass++;
`ifdef DROP_COUNT_EN
      n_checks++;
      if (drop_count !== 8'd1)
         $display("FAIL drop_count_one: got %0d, want 1", drop_count);
      else n_pass++;
`endif
      // A pop in the same cycle does not open the port while full.
      req_a = 1'b1; out_ready = 1'b1;
      #1;
      n_checks++;
      if (grant_a !== 1'b0 || out_valid !== 1'b1 || mem[rd_addr] !== 8'd1)
         $display("FAIL full_pop_no_grant: got g=%b valid=%b data=%0d, want 0 1 1", grant_a, out_valid, mem[rd_addr]);
      else n_pass++;
      tick();
      idle_inputs();
      #1;
      n_checks++;
      if (count !== 3'd3 || rd_addr !== 2'd1 || full !== 1'b0)
         $display("FAIL full_pop_after: got count=%0d rd=%0d full=%b, want 3 1 0", count, rd_addr, full);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [7:0] got;
      logic [7:0] want;
      do_reset();
      req_a = 1'b1; req_b = 1'b1; data_a = 8'hA0; data_b = 8'hB0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (grant_a !== (i % 2 == 0) || grant_b !== (i % 2 == 1) || wr_data !== ((i % 2 == 0) ? 8'hA0 : 8'hB0))
            $display("FAIL rr_grant%0d: got ga=%b gb=%b data=%h, want ga=%b", i, grant_a, grant_b, wr_data, i % 2 == 0);
         else n_pass++;
         exp_q.push_back((i % 2 == 0) ? 8'hA0 : 8'hB0);
         tick();
      end
      idle_inputs();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         got  = mem[rd_addr];
         want = exp_q.pop_front();
         n_checks++;
         if (out_valid !== 1'b1 || got !== want)
            $display("FAIL rr_pop%0d: got valid=%b data=%h, want 1 %h", i, out_valid, got, want);
         else n_pass++;
         tick();
      end
      out_ready = 1'b0;
      #1;
      n_checks++;
      if (empty !== 1'b1)
         $display("FAIL rr_empty: got %b, want 1", empty);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         req_a = 1'b1; data_a = 8'h11 + 8'(i);
         tick();
      end
      req_a = 1'b1; data_a = 8'h14; out_ready = 1'b1;
      #1;
      n_checks++;
      if (grant_a !== 1'b1 || wr_addr !== 2'd3 || rd_addr !== 2'd0 || mem[rd_addr] !== 8'h11)
         $display("FAIL simul_before: got g=%b wr=%0d rd=%0d data=%h, want 1 3 0 11", grant_a, wr_addr, rd_addr, mem[rd_addr]);
      else n_pass++;
      tick();
      idle_inputs();
      #1;
      n_checks++;
      if (count !== 3'd3 || wr_addr !== 2'd0 || rd_addr !== 2'd1)
         $display("FAIL simul_after: got count=%0d wr=%0d rd=%0d, want 3 0 1", count, wr_addr, rd_addr);
      else n_pass++;
   endtask

   task automatic test_wrap();
      int errs;
      errs = 0;
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         req_a = 1'b1; data_a = 8'(i); out_ready = 1'b0;
         #1;
         if (grant_a !== 1'b1 || wr_addr !== 2'((i - 1) % 4)) begin
            errs++;
            $display("FAIL wrap_push%0d: got g=%b wr=%0d, want 1 %0d", i, grant_a, wr_addr, (i - 1) % 4);
         end
         tick();
         req_a = 1'b0; out_ready = 1'b1;
         #1;
         if (out_valid !== 1'b1 || rd_addr !== 2'((i - 1) % 4) || mem[rd_addr] !== 8'(i)) begin
            errs++;
            $display("FAIL wrap_pop%0d: got valid=%b rd=%0d data=%0d, want 1 %0d %0d",
                     i, out_valid, rd_addr, mem[rd_addr], (i - 1) % 4, i);
         end
         tick();
      end
      idle_inputs();
      #1;
      n_checks++;
      if (errs != 0)
         $display("FAIL wrap_sequence: got %0d bad steps, want 0", errs);
      else n_pass++;
      n_checks++;
      if (empty !== 1'b1 || count !== 3'd0 || wr_addr !== 2'd2 || rd_addr !== 2'd2)
         $display("FAIL wrap_end: got empty=%b count=%0d wr=%0d rd=%0d, want 1 0 2 2", empty, count, wr_addr, rd_addr);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      // Leave last_grant pointing at A so the post-reset tie proves it was restored.
      req_a = 1'b1; data_a = 8'h21; tick();
      req_a = 1'b1; data_a = 8'h22; out_ready = 1'b1; tick();
      idle_inputs();
      req_a = 1'b1; data_a = 8'h23; tick();
      idle_inputs();
      #1;
      n_checks++;
      if (count !== 3'd2 || rd_addr !== 2'd1)
         $display("FAIL mid_before: got count=%0d rd=%0d, want 2 1", count, rd_addr);
      else n_pass++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      n_checks++;
      if (count !== 3'd0 || rd_addr !== 2'd0 || out_valid !== 1'b0 || wr_addr !== 2'd0)
         $display("FAIL mid_after: got count=%0d rd=%0d valid=%b wr=%0d, want 0 0 0 0", count, rd_addr, out_valid, wr_addr);
      else n_pass++;
      req_a = 1'b1; req_b = 1'b1;
      #1;
      n_checks++;
      if (grant_a !== 1'b1 || grant_b !== 1'b0)
         $display("FAIL mid_tie: got ga=%b gb=%b, want 1 0", grant_a, grant_b);
      else n_pass++;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_round_robin();
      test_simultaneous();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/circular_buffer_scheduler.md
Name: circular_buffer_scheduler

Overview:
- Controller and arbiter for a buff_size-entry circular buffer register array.
- Two producers share the single write port of the buffer under round-robin arbitration.
- The block generates write enable, write address and write data, plus the read address for a single ready/valid consumer.
- It maintains the wrap-around pointers, occupancy count and full/empty flags.
- The storage array is external; its read is combinational on rd_addr.

Parameters:
- buff_size, 4, number of cells; must be a power of 2.
- word_size, 8, data width in bits.
- addr_size, 2, pointer width; equals log2(buff_size).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_a  input  1  producer A write request.
- data_a  input  word_size  producer A data.
- grant_a  output  1  producer A write accepted this cycle.
- req_b  input  1  producer B write request.
- data_b  input  word_size  producer B data.
- grant_b  output  1  producer B write accepted this cycle.
- wr_en  output  1  write strobe to the storage array.
- wr_addr  output  addr_size  cell to be written.
- wr_data  output  word_size  data of the granted producer.
- rd_addr  output  addr_size  cell currently presented to the consumer.
- out_valid  output  1  cell at rd_addr holds unread data.
- out_ready  input  1  consumer accepts the presented data.
- count  output  addr_size+1  occupancy, range 0..buff_size.
- full  output  1  count == buff_size.
- empty  output  1  count == 0.

Behaviour:
- Registers: wr_ptr, rd_ptr (addr_size bits each), count, last_grant (1 bit; 0 = A served last, 1 = B served last).
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, last_grant = 1 (so A wins the first tie).
  - Resulting outputs: empty = 1, full = 0, out_valid = 0, rd_addr = 0, wr_addr = 0.
  - Grants are forced to 0 while reset is high.
- Grants are combinational in the same cycle as the request:
  - No grant when full = 1, even if a pop occurs in the same cycle.
  - Only one requester active: that requester is granted.
  - Both active: grant the one not in last_grant; on the clock edge, last_grant takes the granted side.
  - No grant: last_grant is unchanged.
- Write outputs:
  - wr_en = grant_a | grant_b.
  - wr_addr = wr_ptr.
  - wr_data = data_a if grant_a, else data_b.
  - The array captures the data on the same posedge.
- Push: on a posedge with wr_en = 1, wr_ptr increments modulo buff_size (natural wrap from 3 to 0).
- Pop:
  - out_valid = !empty; rd_addr = rd_ptr.
  - A pop occurs when out_valid & out_ready; rd_ptr then increments modulo buff_size.
  - out_ready while empty is ignored.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: count unchanged, both pointers advance.
- Latency: data written at edge N is presented at rd_addr from cycle N+1 at the earliest (buffer previously empty).
- Ordering: strict FIFO across both producers, in grant order.
- Reset mid-operation: pointers, count and last_grant return to their reset values on the next posedge. Array contents are not cleared but are treated as invalid.

Optional Feature:
- Macro: DROP_COUNT_EN.
- Defined:
  - Adds output port drop_count, 8 bits.
  - Increments by 1 for each requester asserting req while not granted because full = 1 (by 2 if both are blocked).
  - Saturates at 255; cleared by reset.
  - A producer denied only by arbitration (buffer not full) is not counted.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset asserted for 2 cycles, then released -> count = 0, empty = 1, full = 0, out_valid = 0, rd_addr = 0, no grants.
- req_a only with data 1, 2, 3, 4 on consecutive cycles, out_ready = 0 -> grant_a each cycle, wr_addr 0, 1, 2, 3; count reaches 4, full = 1; a fifth req_a gets no grant; with DROP_COUNT_EN, drop_count = 1.
- req_a and req_b both held with data_a = 8'hA0 and data_b = 8'hB0 -> grants alternate A, B, A, B; consumer pops in order A0, B0, A0, B0.
- Fill to 3 entries, then req_a together with out_ready = 1 -> count stays 3, wr_ptr and rd_ptr both advance.
- Run 10 push/pop pairs -> wr_addr and rd_addr wrap 3 to 0; data sequence 1..10 is read back in order; empty = 1 at the end.
- Reset asserted with count = 2 -> next cycle count = 0, rd_addr = 0, out_valid = 0.
